crumb_sink: RTL and testbench
=============================

# crumb_sink

Terminating receiver for a crumb chain. It samples the last stage's clk_o/rst_no/en_o/rbit_o outputs in the system clock domain and checks that the divided clock and reset lines toggle in lockstep. Once the chain is locked, it assembles the random bit stream into WIDTH-bit words, presents them on a valid/ready port, and counts protocol errors.

## Interface
- WIDTH, 8, bits per output word (≥2)
- LOCK_CNT, 4, consecutive good toggle events required to lock (≥1)
- ERR_W, 8, width of saturating error counter
- clk  in  1  system clock (same clock as the crumb chain)
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  block enable; when low, sampling and FSM freeze, output handshake still operates
- crumb_clk  in  1  chain clk_o
- crumb_rst_n  in  1  chain rst_no
- crumb_en  in  1  chain en_o
- crumb_rbit  in  1  chain rbit_o
- word_ready  in  1  consumer accepts word
- word_data  out  WIDTH  assembled word, first-received bit in MSB
- word_valid  out  1  word_data holds an unconsumed word
- lock  out  1  high in LOCKED state
- overflow  out  1  sticky: a completed word was dropped
- err_count  out  ERR_W  saturating count of toggle-consistency errors

## Operation
- Input stage: all four crumb_* inputs are registered (_q) when en=1. A second register (clk_p) holds the previous crumb_clk_q.
- Event: tog = (crumb_clk_q != clk_p). rise = tog & crumb_clk_q.
- Consistency check: a toggle is good when crumb_rst_n_q == crumb_clk_q. A healthy chain resets both lines to 0 and toggles them together.
- FSM, evaluated only when en=1:
  - IDLE: lock=0. Go to ACQUIRE when crumb_en_q=1, with good_cnt cleared.
  - ACQUIRE:
    - good tog: good_cnt++.
    - bad tog: good_cnt←0 and err_count++.
    - good_cnt reaching LOCK_CNT: go to LOCKED, clearing the shift register and bit count.
  - LOCKED: lock=1.
    - rise with good check: shreg←{shreg[WIDTH-2:0], crumb_rbit_q} and bitcnt++.
    - When bitcnt reaches WIDTH: push the word and set bitcnt←0.
  - Any state except IDLE: crumb_en_q=0 goes to IDLE and discards the partial word.
  - LOCKED, bad tog: err_count++, discard the partial word, go to ACQUIRE with good_cnt=0.
- Priority when events coincide: crumb_en_q=0, then bad tog, then normal progress.
- err_count saturates at all-ones and never wraps.
- Output holding register:
  - Push while word_valid=0: load word_data and set word_valid=1.
  - Push while word_valid=1 and word_ready=1 in the same cycle: load the new word and keep word_valid=1 (replace).
  - Push while word_valid=1 and word_ready=0: drop the new word, keep the old word, set overflow=1.
  - No push while word_valid=1 and word_ready=1: word_valid←0 next cycle.
- Reset mid-operation clears everything, including the sticky overflow flag and err_count.

## Timing
- Reset values: word_data=0, word_valid=0, lock=0, overflow=0, err_count=0. Internal state: FSM=IDLE, all _q registers=0, clk_p=0, shreg=0, bitcnt=0, good_cnt=0.
- Latency: a crumb input change at edge N is sampled into _q. tog is visible combinationally after edge N, and the FSM, shreg, and counters update at edge N+1.
- A word's last bit sampled at edge N gives word_valid=1 after edge N+1.
- lock rises at the edge that consumes the LOCK_CNT-th good toggle.
- The chain toggles at most once per cycle. Minimum spacing is therefore 2 cycles per rise and 2·WIDTH cycles per word.
- en=0 holds _q, clk_p, and the FSM. The first toggle seen after en returns to 1 is compared against the held clk_p.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random crumb inputs → all outputs 0, lock=0.
- Lock: crumb_en=1, toggle clk/rst_n together every cycle → lock=1 at the edge consuming the 4th toggle, err_count=0.
- Word: locked; drive rbit on 8 rises with the sequence 1,0,1,0,0,1,0,1 and word_ready=1 → word_data=0xA5 with word_valid for 1 cycle.
- Mismatch: locked, 3 bits into a word; toggle crumb_clk without crumb_rst_n → lock=0, err_count=1, partial word discarded. After 4 good toggles, lock=1 and the next word is aligned from a fresh bit 0.
- Overflow: word_ready=0 for 2 full words → first word retained, overflow=1. Then assert word_ready=1 → first word consumed, overflow stays 1 until reset.
- Enable drop: drop crumb_en mid-word → FSM returns to IDLE, no word emitted. Force 300 bad toggles → err_count=255 (saturated).

Source files
------------

// File: rtl/crumb_sink.sv
// Terminating receiver for a crumb chain: checks that clk/rst_n toggle in lockstep,
// locks after LOCK_CNT good toggles and packs rbit samples into WIDTH-bit words.
module crumb_sink #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             crumb_clk,
    input  logic             crumb_rst_n,
    input  logic             crumb_en,
    input  logic             crumb_rbit,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_data,
    output logic             word_valid,
    output logic             lock,
    output logic             overflow,
    output logic [ERR_W-1:0] err_count
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    state_t           state, state_n;
    logic             clk_q, rst_q, en_q, rbit_q, clk_p;
    logic [GW-1:0]    good_cnt, good_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [BW-1:0]    bitcnt, bitcnt_n;
    logic             push, err_inc;
    logic             tog, rise, bad_tog;

    assign tog     = clk_q != clk_p;
    assign rise    = tog & clk_q;
    // A healthy chain drives rst_n to the same level as clk after every toggle.
    assign bad_tog = tog & (rst_q != clk_q);
    assign lock    = (state == LOCKED);

    always_comb begin
        state_n  = state;
        good_n   = good_cnt;
        shreg_n  = shreg;
        bitcnt_n = bitcnt;
        push     = 1'b0;
        err_inc  = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (en_q) begin
                        state_n = ACQUIRE;
                        good_n  = '0;
                    end
                end
                ACQUIRE: begin
                    if (!en_q) begin
                        state_n = IDLE;
                    end else if (bad_tog) begin
                        good_n  = '0;
                        err_inc = 1'b1;
                    end else if (tog) begin
                        if (good_cnt == GW'(LOCK_CNT - 1)) begin
                            state_n  = LOCKED;
                            shreg_n  = '0;
                            bitcnt_n = '0;
                        end else begin
                            good_n = good_cnt + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (!en_q) begin
                        state_n  = IDLE;
                        shreg_n  = '0;
                        bitcnt_n = '0;
                    end else if (bad_tog) begin
                        state_n  = ACQUIRE;
                        good_n   = '0;
                        err_inc  = 1'b1;
                        shreg_n  = '0;
                        bitcnt_n = '0;
                    end else if (rise) begin
                        shreg_n = {shreg[WIDTH-2:0], rbit_q};
                        if (bitcnt == BW'(WIDTH - 1)) begin
                            push     = 1'b1;
                            bitcnt_n = '0;
                        end else begin
                            bitcnt_n = bitcnt + 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            clk_q     <= 1'b0;
            rst_q     <= 1'b0;
            en_q      <= 1'b0;
            rbit_q    <= 1'b0;
            clk_p     <= 1'b0;
            good_cnt  <= '0;
            shreg     <= '0;
            bitcnt    <= '0;
            err_count <= '0;
        end else if (en) begin
            state    <= state_n;
            clk_q    <= crumb_clk;
            rst_q    <= crumb_rst_n;
            en_q     <= crumb_en;
            rbit_q   <= crumb_rbit;
            clk_p    <= clk_q;
            good_cnt <= good_n;
            shreg    <= shreg_n;
            bitcnt   <= bitcnt_n;
            if (err_inc && (err_count != '1))
                err_count <= err_count + 1'b1;
        end
    end

    // Holding register keeps running while en=0 so the consumer can drain it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_data  <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (push) begin
            if (!word_valid || word_ready) begin
                word_data  <= shreg_n;
                word_valid <= 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_crumb_sink.sv
// Randomized and directed bench for crumb_sink against a bit-queue reference model.
module tb_crumb_sink;
    localparam int WIDTH    = 8;
    localparam int LOCK_CNT = 4;
    localparam int ERR_W    = 8;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             crumb_clk = 1'b0, crumb_rst_n = 1'b0, crumb_en = 1'b0, crumb_rbit = 1'b0;
    logic             word_ready = 1'b0;
    logic [WIDTH-1:0] word_data;
    logic             word_valid, lock, overflow;
    logic [ERR_W-1:0] err_count;

    crumb_sink #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .crumb_clk(crumb_clk), .crumb_rst_n(crumb_rst_n), .crumb_en(crumb_en), .crumb_rbit(crumb_rbit),
        .word_ready(word_ready), .word_data(word_data), .word_valid(word_valid),
        .lock(lock), .overflow(overflow), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: sampled inputs, lock status, bits collected so far, output slot.
    bit s_clk, s_rst, s_en, s_bit, p_clk;
    bit m_active, m_locked, m_valid, m_ovf;
    int m_run, m_err, m_word;
    bit bits[$];

    task automatic model_reset();
        s_clk = 0; s_rst = 0; s_en = 0; s_bit = 0; p_clk = 0;
        m_active = 0; m_locked = 0; m_valid = 0; m_ovf = 0;
        m_run = 0; m_err = 0; m_word = 0;
        bits.delete();
    endtask

    task automatic model_step();
        bit push, t, ok;
        int pw;
        push = 0;
        pw = 0;
        if (en) begin
            t  = (s_clk != p_clk);
            ok = (s_rst == s_clk);
            if (!m_active) begin
                if (s_en) begin m_active = 1; m_locked = 0; m_run = 0; end
            end else if (!s_en) begin
                m_active = 0; m_locked = 0; bits.delete();
            end else if (t && !ok) begin
                if (m_err < ERR_MAX) m_err++;
                m_locked = 0; m_run = 0; bits.delete();
            end else if (!m_locked) begin
                if (t) begin
                    m_run++;
                    if (m_run >= LOCK_CNT) begin m_locked = 1; bits.delete(); end
                end
            end else if (t && s_clk) begin
                bits.push_back(s_bit);
                if (bits.size() == WIDTH) begin
                    foreach (bits[i]) pw = pw * 2 + int'(bits[i]);
                    push = 1;
                    bits.delete();
                end
            end
        end
        if (push) begin
            if (!m_valid || word_ready) begin m_word = pw; m_valid = 1; end
            else m_ovf = 1;
        end else if (m_valid && word_ready) begin
            m_valid = 0;
        end
        if (en) begin
            p_clk = s_clk;
            s_clk = crumb_clk; s_rst = crumb_rst_n; s_en = crumb_en; s_bit = crumb_rbit;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        chk("lock", lock, m_locked);
        chk("valid", word_valid, m_valid);
        chk("data", word_data, m_word);
        chk("ovf", overflow, m_ovf);
        chk("err", err_count, m_err);
    endtask

    bit cc = 0;

    task automatic tog_good(input bit b);
        cc = !cc;
        crumb_clk = cc; crumb_rst_n = cc; crumb_rbit = b;
        tick();
    endtask

    task automatic tog_bad();
        cc = !cc;
        crumb_clk = cc; crumb_rst_n = !cc;
        tick();
    endtask

    task automatic send_bit(input bit b);
        if (cc) tog_good(1'b0);
        tog_good(b);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] v;
        v = w;
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic relock();
        for (int i = 0; i < LOCK_CNT; i++) tog_good(1'b0);
        tick(); tick();
        chk("relock", lock, 1);
    endtask

    initial begin
        logic [WIDTH-1:0] w1, w2;
        model_reset();
        // Reset with random crumb activity.
        for (int i = 0; i < 3; i++) begin
            crumb_clk = 1'($urandom); crumb_rst_n = 1'($urandom);
            crumb_en = 1'($urandom); crumb_rbit = 1'($urandom);
            tick();
        end
        chk("rst_lock", lock, 0);
        chk("rst_valid", word_valid, 0);
        crumb_clk = 0; crumb_rst_n = 0; crumb_en = 0; crumb_rbit = 0; cc = 0;
        rst_n = 1; en = 1; word_ready = 1;
        tick();

        crumb_en = 1;
        tick(); tick();
        relock();
        chk("lock_err", err_count, 0);

        send_word(8'hA5);
        tick();
        chk("a5_valid", word_valid, 1);
        chk("a5_data", word_data, 8'hA5);
        tick();
        chk("a5_pop", word_valid, 0);

        // Break lockstep three bits into a word, then re-acquire.
        send_bit(1); send_bit(1); send_bit(1);
        tog_bad();
        tick(); tick();
        chk("mm_lock", lock, 0);
        chk("mm_err", err_count, 1);
        relock();
        send_word(8'h3C);
        tick();
        chk("mm_data", word_data, 8'h3C);
        chk("mm_valid", word_valid, 1);
        tick();

        // Two words with no consumer.
        word_ready = 0;
        w1 = WIDTH'($urandom); w2 = ~w1;
        send_word(w1);
        send_word(w2);
        tick(); tick();
        chk("ovf_flag", overflow, 1);
        chk("ovf_keep", word_data, w1);
        chk("ovf_valid", word_valid, 1);
        word_ready = 1;
        tick();
        chk("ovf_pop", word_valid, 0);
        chk("ovf_sticky", overflow, 1);

        // Drop crumb_en mid-word.
        send_bit(0); send_bit(1); send_bit(1);
        crumb_en = 0;
        tick(); tick(); tick();
        chk("drop_lock", lock, 0);
        for (int i = 0; i < WIDTH; i++) send_bit(1'($urandom));
        tick(); tick();
        chk("drop_noword", word_valid, 0);

        // Block enable freeze: toggles while en=0 must not advance lock.
        crumb_en = 1;
        tick(); tick();
        en = 0;
        for (int i = 0; i < 6; i++) tog_good(1'b0);
        chk("freeze_lock", lock, 0);
        en = 1;
        tick(); tick(); tick();

        // Saturate the error counter.
        for (int i = 0; i < 300; i++) tog_bad();
        tick(); tick();
        chk("err_sat", err_count, ERR_MAX);

        rst_n = 0;
        tick();
        chk("rst2_ovf", overflow, 0);
        chk("rst2_err", err_count, 0);
        rst_n = 1;

        // Randomized run.
        for (int i = 0; i < 6000; i++) begin
            en = ($urandom % 8) != 0;
            word_ready = 1'($urandom);
            crumb_en = ($urandom % 200) != 0;
            rst_n = ($urandom % 1500) != 0;
            crumb_rbit = 1'($urandom);
            if ($urandom % 2) begin
                cc = !cc;
                crumb_clk = cc;
                crumb_rst_n = (($urandom % 64) != 0) ? cc : !cc;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
